// File: rtl/dm_arbiter.sv
// dm_arbiter
// Round-robin arbiter that shares one single-port synchronous data memory
// between N_CORES cores. One access is serviced at a time:
//   IDLE   : pick a winner (round-robin from last+1), latch its request
//   ACCESS : drive the memory strobe, one-hot gnt to the winner
//   RDATA  : (loads only) return mem_rdata with one-hot rvalid
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req/we              per-core request and store qualifier
//   addr/wdata          per-core address / store data, core i at [i*W +: W]
//   gnt, rvalid         one-hot grant / read-valid, one cycle each
//   rdata               read data broadcast to all cores (holds when idle)
//   mem_en/mem_we       memory strobe / write enable
//   mem_addr/mem_wdata  latched address / store data (held between accesses)
//   mem_rdata           memory read data, valid the cycle after a read strobe
//   busy                high whenever not in IDLE
module dm_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES-1:0]        we,
  input  logic [N_CORES*ADDR_W-1:0] addr,
  input  logic [N_CORES*DATA_W-1:0] wdata,
  output logic [N_CORES-1:0]        gnt,
  output logic [N_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  // Round-robin pick: scan last+1, last+2, ... wrapping mod N_CORES, so the
  // most recent winner is the last to be considered.
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      idx = (int'(last_q) + k) % N_CORES;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(idx);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          last_d  = pick_idx;
          we_d    = we[pick_idx];
          addr_d  = addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          wdata_d = wdata[int'(pick_idx)*DATA_W +: DATA_W];
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = we_q ? IDLE : RDATA;
      RDATA: begin
        rdata_d = mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N_CORES - 1);  // core 0 has first priority
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are decoded from the registered state; address/data come straight
  // from the latches so they hold between accesses.
  always_comb begin
    gnt    = '0;
    rvalid = '0;
    if (state_q == ACCESS) gnt[win_q]    = 1'b1;
    if (state_q == RDATA)  rvalid[win_q] = 1'b1;
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  // Forward memory data during RDATA; afterwards show the captured copy.
  assign rdata     = (state_q == RDATA) ? mem_rdata : rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter (N_CORES=4, 16-bit address/data) with a small
// synchronous memory model behind the shared port.
module tb_dm_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Synchronous single-port memory; reset preloads mem[0x10]=0x1234.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      mem[16]   <= 16'h1234;
      mem[32]   <= 16'h5A5A;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r;
    we[i]  = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  // Runs until n_exp grants are seen (bounded); cores drop req after their
  // grant unless keep_mask holds them.
  task automatic grant_seq(input string tag, input int n_exp,
                           input logic [N-1:0] exp0, input logic [N-1:0] exp1,
                           input logic [N-1:0] exp2, input logic [N-1:0] exp3,
                           input logic [N-1:0] keep_mask);
    logic [N-1:0] exp_q [4];
    int n;
    exp_q[0] = exp0; exp_q[1] = exp1; exp_q[2] = exp2; exp_q[3] = exp3;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < n_exp; cyc++) begin
      tick();
      if (gnt != '0) begin
        chk(tag, gnt, exp_q[n]);
        req = req & (~gnt | keep_mask);
        n++;
      end
    end
    chk({tag, "_count"}, n, n_exp);
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;

    // Single load by core 0
    set_core(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    tick();
    chk("ld_gnt", gnt, 4'b0001);
    chk("ld_mem_en", mem_en, 1);
    chk("ld_mem_we", mem_we, 0);
    chk("ld_mem_addr", mem_addr, 16'h0010);
    chk("ld_busy", busy, 1);
    req = '0;
    tick();
    chk("ld_rvalid", rvalid, 4'b0001);
    chk("ld_rdata", rdata, 16'h1234);
    tick();
    chk("ld_idle_rvalid", rvalid, 0);
    chk("ld_idle_busy", busy, 0);

    // Core 2 stores 0xBEEF to 0x0005, then loads it back
    set_core(2, 1'b1, 1'b1, 16'h0005, 16'hBEEF);
    tick();
    chk("st_gnt", gnt, 4'b0100);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_addr", mem_addr, 16'h0005);
    chk("st_mem_wdata", mem_wdata, 16'hBEEF);
    req = '0;
    tick();
    chk("st_done_busy", busy, 0);
    chk("st_done_mem_en", mem_en, 0);
    chk("st_hold_addr", mem_addr, 16'h0005);
    set_core(2, 1'b1, 1'b0, 16'h0005, 16'h0);
    tick();
    chk("ld2_gnt", gnt, 4'b0100);
    chk("ld2_mem_we", mem_we, 0);
    req = '0;
    tick();
    chk("ld2_rvalid", rvalid, 4'b0100);
    chk("ld2_rdata", rdata, 16'hBEEF);
    tick();
    chk("ld2_rdata_hold", rdata, 16'hBEEF);

    // Contention from reset: all four store, order 0,1,2,3
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b1, AW'(16'h40 + i), DW'(i));
    grant_seq("cont", 4, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000);
    req = '0; tick(); tick();

    // Fairness: core 0 keeps requesting, core 3 must get in before core 0 again
    rst = 1'b1; tick(); rst = 1'b0;
    set_core(0, 1'b1, 1'b1, 16'h0050, 16'h1111);
    set_core(3, 1'b1, 1'b1, 16'h0053, 16'h3333);
    grant_seq("fair", 3, 4'b0001, 4'b1000, 4'b0001, 4'b0000, 4'b0001);
    req = '0; tick(); tick();

    // Reset during the RDATA cycle of a core 1 load
    rst = 1'b1; tick(); rst = 1'b0;
    we = '0;
    set_core(1, 1'b1, 1'b0, 16'h0020, 16'h0);
    tick();
    chk("rrd_gnt", gnt, 4'b0010);
    req = '0;
    tick();
    chk("rrd_rvalid", rvalid, 4'b0010);
    chk("rrd_rdata", rdata, 16'h5A5A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rrd_rvalid_drop", rvalid, 0);
    chk("rrd_busy", busy, 0);
    chk("rrd_rdata_rst", rdata, 0);
    set_core(0, 1'b1, 1'b1, 16'h0060, 16'hAAAA);
    set_core(1, 1'b1, 1'b1, 16'h0061, 16'hBBBB);
    tick();
    chk("rrd_first", gnt, 4'b0001);
    req[0] = 1'b0;
    tick();
    tick();
    chk("rrd_second", gnt, 4'b0010);
    req = '0;
    tick();

    // Core 0 wins (last=0), then reset coincides with req=0011: no latch,
    // and afterwards core 0 again has first priority.
    set_core(0, 1'b1, 1'b1, 16'h0070, 16'hCCCC);
    tick();
    chk("sim_pre_gnt", gnt, 4'b0001);
    req = '0;
    tick();
    rst = 1'b1;
    req = 4'b0011;
    tick();
    chk("sim_rst_busy", busy, 0);
    chk("sim_rst_gnt", gnt, 0);
    rst = 1'b0;
    tick();
    chk("sim_after_gnt", gnt, 4'b0001);
    req = '0;
    tick(); tick();

    // Idle stability
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle", {mem_en, gnt, rvalid, busy}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
